ring_phase_decoder: RTL and testbench

RING_PHASE_DECODER -- requirements
Module: ring_phase_decoder

---
 rtl/ring_phase_decoder_pkg.sv | 14 +
 rtl/ring_phase_decoder_onehot_to_bin.sv | 27 ++
 rtl/ring_phase_decoder.sv | 145 ++++++++++++++
 tb/tb_ring_phase_decoder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ring_phase_decoder_pkg.sv
// Shared types and constants for the ring phase decoder.
//   state_e : tracking FSM states (hunt for a phase, acquire sequence, locked on ring)
//   ErrCntW : width of the saturating error counter
package ring_phase_decoder_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StAcq,
    StLocked
  } state_e;

  localparam int unsigned ErrCntW = 8;

endpackage

// File: rtl/ring_phase_decoder_onehot_to_bin.sv
// Combinational one-hot to binary converter.
//   vec : one-hot input vector (CNT_SIZE bits)
//   bin : position of the set bit; only meaningful when ok=1
//   ok  : high when exactly one bit of vec is set
module onehot_to_bin #(
  parameter int unsigned CNT_SIZE = 8,
  parameter int unsigned IDX_W    = $clog2(CNT_SIZE)
) (
  input  logic [CNT_SIZE-1:0] vec,
  output logic [IDX_W-1:0]    bin,
  output logic                ok
);

  // OR of the indices of all set bits; exact whenever the input is one-hot.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < CNT_SIZE; i++) begin
      if (vec[i]) begin
        bin = bin | IDX_W'(i);
      end
    end
  end

  // Non-zero with no second bit: clearing the lowest set bit must leave nothing.
  assign ok = (vec != '0) && ((vec & (vec - CNT_SIZE'(1))) == '0);

endmodule

// File: rtl/ring_phase_decoder.sv
// Ring phase decoder: converts a right-rotating one-hot ring phase into a binary
// index, acquires lock on the rotation sequence and flags/counts errors.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   phase_in   : one-hot phase vector
//   phase_vld  : sample qualifier
//   clr_err    : synchronous clear of err_cnt (wins over a same-cycle error)
//   idx        : binary position of the last good sample
//   idx_vld    : one-cycle pulse when idx is loaded
//   locked     : high while in the locked state
//   err_onehot : one-cycle pulse for a sample that is not exactly one-hot
//   err_seq    : one-cycle pulse for a one-hot sample off the flywheel while locked
//   err_cnt    : saturating count of error pulses
module ring_phase_decoder
  import ring_phase_decoder_pkg::*;
#(
  parameter int unsigned CNT_SIZE = 8,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned MISS_MAX = 2,
  localparam int unsigned IDX_W   = $clog2(CNT_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_SIZE-1:0] phase_in,
  input  logic                phase_vld,
  input  logic                clr_err,
  output logic [IDX_W-1:0]    idx,
  output logic                idx_vld,
  output logic                locked,
  output logic                err_onehot,
  output logic                err_seq,
  output logic [ErrCntW-1:0]  err_cnt
);

  state_e           state;
  logic [IDX_W-1:0] exp_idx;
  logic [3:0]       match_cnt;
  logic [3:0]       miss_cnt;

  logic [IDX_W-1:0] samp_idx;
  logic             samp_ok;
  logic             hit;
  logic [IDX_W-1:0] samp_prev;
  logic [IDX_W-1:0] exp_prev;
  logic [3:0]       match_inc;
  logic [3:0]       miss_inc;
  logic             err_any;

  onehot_to_bin #(
    .CNT_SIZE(CNT_SIZE),
    .IDX_W   (IDX_W)
  ) u_onehot_to_bin (
    .vec(phase_in),
    .bin(samp_idx),
    .ok (samp_ok)
  );

  // Right rotation: successor of index k is (k-1) mod CNT_SIZE.
  always_comb begin
    samp_prev = (samp_idx == '0) ? IDX_W'(CNT_SIZE - 1) : samp_idx - IDX_W'(1);
    exp_prev  = (exp_idx == '0)  ? IDX_W'(CNT_SIZE - 1) : exp_idx - IDX_W'(1);
    hit       = samp_ok && (samp_idx == exp_idx);
    match_inc = match_cnt + 4'd1;
    miss_inc  = miss_cnt + 4'd1;
    err_any   = phase_vld && (!samp_ok || ((state == StLocked) && !hit));
  end

  assign locked = (state == StLocked);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= StHunt;
      idx        <= '0;
      idx_vld    <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_cnt    <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      exp_idx    <= '0;
    end else begin
      idx_vld    <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;

      if (clr_err) begin
        err_cnt <= '0;
      end else if (err_any && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ErrCntW'(1);
      end

      if (phase_vld) begin
        if (samp_ok) begin
          idx     <= samp_idx;
          idx_vld <= 1'b1;
        end else begin
          err_onehot <= 1'b1;
        end

        unique case (state)
          StHunt: begin
            if (samp_ok) begin
              exp_idx   <= samp_prev;
              match_cnt <= '0;
              state     <= StAcq;
            end
          end
          StAcq: begin
            if (!samp_ok) begin
              state <= StHunt;
            end else if (hit) begin
              exp_idx   <= exp_prev;
              match_cnt <= match_inc;
              if (match_inc == 4'(LOCK_CNT)) begin
                state    <= StLocked;
                miss_cnt <= '0;
              end
            end else begin
              // Resynchronise on the new phase without flagging an error.
              exp_idx   <= samp_prev;
              match_cnt <= '0;
            end
          end
          StLocked: begin
            // Flywheel: the expectation free-runs and ignores sample content.
            exp_idx <= exp_prev;
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              if (samp_ok) begin
                err_seq <= 1'b1;
              end
              miss_cnt <= miss_inc;
              if (miss_inc >= 4'(MISS_MAX)) begin
                state <= StHunt;
              end
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Directed self-checking bench for ring_phase_decoder (CNT_SIZE=8, LOCK_CNT=3, MISS_MAX=2).
module tb_ring_phase_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] phase_in;
  logic       phase_vld;
  logic       clr_err;
  logic [2:0] idx;
  logic       idx_vld;
  logic       locked;
  logic       err_onehot;
  logic       err_seq;
  logic [7:0] err_cnt;

  int passed = 0;
  int total  = 0;

  ring_phase_decoder #(
    .CNT_SIZE(8),
    .LOCK_CNT(3),
    .MISS_MAX(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .phase_in  (phase_in),
    .phase_vld (phase_vld),
    .clr_err   (clr_err),
    .idx       (idx),
    .idx_vld   (idx_vld),
    .locked    (locked),
    .err_onehot(err_onehot),
    .err_seq   (err_seq),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic v, input logic [7:0] ph, input logic c, input logic r);
    @(negedge clk);
    phase_vld = v;
    phase_in  = ph;
    clr_err   = c;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] e_idx, input logic e_vld,
                            input logic e_lock, input logic e_eo, input logic e_es,
                            input logic [31:0] e_cnt);
    chk({tag, ".idx"},        32'(idx),        e_idx);
    chk({tag, ".idx_vld"},    32'(idx_vld),    32'(e_vld));
    chk({tag, ".locked"},     32'(locked),     32'(e_lock));
    chk({tag, ".err_onehot"}, 32'(err_onehot), 32'(e_eo));
    chk({tag, ".err_seq"},    32'(err_seq),    32'(e_es));
    chk({tag, ".err_cnt"},    32'(err_cnt),    e_cnt);
  endtask

  initial begin
    rst       = 1'b0;
    phase_in  = 8'h00;
    phase_vld = 1'b0;
    clr_err   = 1'b0;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    expect_all("reset", 0, 0, 0, 0, 0, 0);

    // Lock on 0,7,6,5
    step(1'b1, 8'h01, 1'b0, 1'b1); expect_all("lock0", 0, 1, 0, 0, 0, 0);
    step(1'b1, 8'h80, 1'b0, 1'b1); expect_all("lock1", 7, 1, 0, 0, 0, 0);
    step(1'b1, 8'h40, 1'b0, 1'b1); expect_all("lock2", 6, 1, 0, 0, 0, 0);
    step(1'b1, 8'h20, 1'b0, 1'b1); expect_all("lock3", 5, 1, 1, 0, 0, 0);

    // Idle cycle with garbage on phase_in: everything holds, no pulses
    step(1'b0, 8'h03, 1'b0, 1'b1); expect_all("idle", 5, 0, 1, 0, 0, 0);

    // Walk down to the wrap point and across it
    step(1'b1, 8'h10, 1'b0, 1'b1); expect_all("walk4", 4, 1, 1, 0, 0, 0);
    step(1'b1, 8'h08, 1'b0, 1'b1); expect_all("walk3", 3, 1, 1, 0, 0, 0);
    step(1'b1, 8'h04, 1'b0, 1'b1); expect_all("walk2", 2, 1, 1, 0, 0, 0);
    step(1'b1, 8'h02, 1'b0, 1'b1); expect_all("wrap1", 1, 1, 1, 0, 0, 0);
    step(1'b1, 8'h01, 1'b0, 1'b1); expect_all("wrap0", 0, 1, 1, 0, 0, 0);
    step(1'b1, 8'h80, 1'b0, 1'b1); expect_all("wrap7", 7, 1, 1, 0, 0, 0);

    // Skip: 0x20 arrives where 6 was expected; flywheel then expects 5
    step(1'b1, 8'h20, 1'b0, 1'b1); expect_all("skip", 5, 1, 1, 0, 1, 1);
    step(1'b1, 8'h20, 1'b0, 1'b1); expect_all("fly_hit", 5, 1, 1, 0, 0, 1);
    // One bad sample after the hit must not drop lock (miss count was cleared)
    step(1'b1, 8'h03, 1'b0, 1'b1); expect_all("miss1", 5, 0, 1, 1, 0, 2);
    step(1'b1, 8'h08, 1'b0, 1'b1); expect_all("recover", 3, 1, 1, 0, 0, 2);

    // clr_err on an idle cycle
    step(1'b0, 8'h00, 1'b1, 1'b1); expect_all("clr_idle", 3, 0, 1, 0, 0, 0);

    // Bad one-hot while locked, then a second bad sample loses lock
    step(1'b1, 8'h03, 1'b0, 1'b1); expect_all("bad2bit", 3, 0, 1, 1, 0, 1);
    step(1'b1, 8'h00, 1'b0, 1'b1); expect_all("bad0bit", 3, 0, 0, 1, 0, 2);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'hff, 1'b0, 1'b1);
    end
    expect_all("sat", 3, 0, 0, 1, 0, 255);
    step(1'b1, 8'h00, 1'b1, 1'b1); expect_all("clr_win", 3, 0, 0, 1, 0, 0);

    // Relock from HUNT with one error on the counter, then reset mid-stream
    step(1'b1, 8'h00, 1'b0, 1'b1); expect_all("hunt_bad", 3, 0, 0, 1, 0, 1);
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h80, 1'b0, 1'b1);
    step(1'b1, 8'h40, 1'b0, 1'b1);
    step(1'b1, 8'h20, 1'b0, 1'b1); expect_all("relock", 5, 1, 1, 0, 0, 1);
    step(1'b1, 8'h10, 1'b1, 1'b0); expect_all("mid_rst", 0, 0, 0, 0, 0, 0);

    // After reset, lock needs LOCK_CNT+1 good samples again
    step(1'b1, 8'h08, 1'b0, 1'b1); expect_all("post0", 3, 1, 0, 0, 0, 0);
    step(1'b1, 8'h04, 1'b0, 1'b1); expect_all("post1", 2, 1, 0, 0, 0, 0);
    step(1'b1, 8'h02, 1'b0, 1'b1); expect_all("post2", 1, 1, 0, 0, 0, 0);
    step(1'b1, 8'h01, 1'b0, 1'b1); expect_all("post3", 0, 1, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
